// File: rtl/led_pattern_gen.sv
// LED pattern generator: a programmable prescaler steps an N-bit LED vector
// through rotate-left, rotate-right, bounce or binary-count patterns.
module led_pattern_gen #(
  parameter int unsigned N        = 3,
  parameter int unsigned PERIOD_W = 32
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                enable,
  input  logic [1:0]          mode,
  input  logic [PERIOD_W-1:0] period,
  output logic [N-1:0]        led,
  output logic                tick,
  output logic                dir
);

  typedef enum logic [1:0] {
    ROT_L  = 2'd0,
    ROT_R  = 2'd1,
    BOUNCE = 2'd2,
    COUNT  = 2'd3
  } mode_t;

  localparam logic [N-1:0] LED_ONE = {{(N-1){1'b0}}, 1'b1};

  mode_t               mode_in;
  mode_t               mode_q, mode_q_nxt;
  logic [PERIOD_W-1:0] cnt, cnt_nxt;
  logic [N-1:0]        led_nxt, step_led, init_led;
  logic                tick_nxt, dir_nxt, step_dir;

  assign mode_in  = mode_t'(mode);
  assign init_led = (mode_in == COUNT) ? '0 : LED_ONE;

  // Pattern advance for the registered mode, used only when a step fires.
  always_comb begin
    step_led = led;
    step_dir = dir;
    unique case (mode_q)
      ROT_L:  step_led = {led[N-2:0], led[N-1]};
      ROT_R:  step_led = {led[0], led[N-1:1]};
      BOUNCE: begin
        if (!dir && led[N-1]) begin
          step_dir = 1'b1;
          step_led = led >> 1;
        end else if (dir && led[0]) begin
          step_dir = 1'b0;
          step_led = led << 1;
        end else if (dir) begin
          step_led = led >> 1;
        end else begin
          step_led = led << 1;
        end
      end
      COUNT:  step_led = led + LED_ONE;
    endcase
  end

  // Reset and mode change both reload the initial pattern; reset leaves
  // mode_q at ROT_L so a non-zero mode is re-applied on the first free edge.
  always_comb begin
    mode_q_nxt = mode_q;
    cnt_nxt    = cnt;
    led_nxt    = led;
    dir_nxt    = dir;
    tick_nxt   = 1'b0;
    if (!resetn) begin
      mode_q_nxt = ROT_L;
      cnt_nxt    = '0;
      led_nxt    = init_led;
      dir_nxt    = 1'b0;
    end else if (mode_in != mode_q) begin
      mode_q_nxt = mode_in;
      cnt_nxt    = '0;
      led_nxt    = init_led;
      dir_nxt    = 1'b0;
    end else if (enable) begin
      if (cnt >= period) begin
        cnt_nxt  = '0;
        tick_nxt = 1'b1;
        led_nxt  = step_led;
        dir_nxt  = step_dir;
      end else begin
        cnt_nxt = cnt + PERIOD_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    mode_q <= mode_q_nxt;
    cnt    <= cnt_nxt;
    led    <= led_nxt;
    tick   <= tick_nxt;
    dir    <= dir_nxt;
  end

endmodule

// File: tb/tb_led_pattern_gen.sv
// Directed bench for led_pattern_gen: vector table plus hand-written
// sequences for pause, mode switch, period shrink and mid-sweep reset.
module tb_led_pattern_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        r3, e3, t3, d3;
  logic [1:0]  m3;
  logic [31:0] p3;
  logic [2:0]  led3;
  logic        r4, e4, t4, d4;
  logic [1:0]  m4;
  logic [31:0] p4;
  logic [3:0]  led4;

  led_pattern_gen #(.N(3), .PERIOD_W(32)) dut3 (
    .clk(clk), .resetn(r3), .enable(e3), .mode(m3), .period(p3),
    .led(led3), .tick(t3), .dir(d3)
  );

  led_pattern_gen #(.N(4), .PERIOD_W(32)) dut4 (
    .clk(clk), .resetn(r4), .enable(e4), .mode(m4), .period(p4),
    .led(led4), .tick(t4), .dir(d4)
  );

  typedef struct {
    bit          which;
    bit          rstn;
    bit          en;
    logic [1:0]  mode;
    logic [31:0] period;
    logic [3:0]  exp_led;
    bit          exp_tick;
    bit          exp_dir;
  } vec_t;

  vec_t vecs[$];
  int   n_cmp  = 0;
  int   n_fail = 0;

  localparam logic [3:0] BL [11] = '{4'd1, 4'd2, 4'd4, 4'd8, 4'd4, 4'd2,
                                     4'd1, 4'd2, 4'd4, 4'd8, 4'd4};
  localparam bit         BD [11] = '{0, 0, 0, 0, 1, 1, 1, 0, 0, 0, 1};
  localparam logic [2:0] RL [4]  = '{3'b001, 3'b010, 3'b100, 3'b001};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_out(input string tag, input bit which, input logic [3:0] el,
                         input bit et, input bit ed);
    if (which) begin
      chk({tag, " led"},  32'(led4), 32'(el));
      chk({tag, " tick"}, 32'(t4),   32'(et));
      chk({tag, " dir"},  32'(d4),   32'(ed));
    end else begin
      chk({tag, " led"},  32'(led3), 32'(el));
      chk({tag, " tick"}, 32'(t3),   32'(et));
      chk({tag, " dir"},  32'(d3),   32'(ed));
    end
  endtask

  task automatic edge1();
    @(posedge clk);
    #1;
  endtask

  task automatic drive3(input bit r, input bit e, input logic [1:0] m, input logic [31:0] p);
    r3 = r; e3 = e; m3 = m; p3 = p;
  endtask

  function automatic void add(input bit w, input bit r, input bit e, input logic [1:0] m,
                              input logic [31:0] p, input logic [3:0] el,
                              input bit et, input bit ed);
    vec_t v;
    v.which = w; v.rstn = r; v.en = e; v.mode = m; v.period = p;
    v.exp_led = el; v.exp_tick = et; v.exp_dir = ed;
    vecs.push_back(v);
  endfunction

  initial begin
    bit saw_tick;
    drive3(1'b0, 1'b1, 2'd0, 32'd3);
    r4 = 1'b0; e4 = 1'b1; m4 = 2'd2; p4 = 32'd0;

    // ROT_L, N=3, P=3: steps on edges 4, 8, 12 after release
    add(0, 0, 1, 2'd0, 32'd3, 4'b0001, 0, 0);
    for (int k = 1; k <= 12; k++)
      add(0, 1, 1, 2'd0, 32'd3, {1'b0, RL[k/4]}, (k % 4) == 0, 0);

    // COUNT, N=3, P=1: one mode-reload edge after release, then steps on odd edges
    add(0, 0, 1, 2'd3, 32'd1, 4'b0000, 0, 0);
    for (int k = 1; k <= 17; k++)
      add(0, 1, 1, 2'd3, 32'd1, 4'((((k - 1) / 2)) % 8), (k >= 3) && (k % 2 == 1), 0);

    // BOUNCE, N=4, P=0, then reset mid-sweep (dir=1, led=0100)
    add(1, 0, 1, 2'd2, 32'd0, 4'b0001, 0, 0);
    for (int k = 0; k < 11; k++)
      add(1, 1, 1, 2'd2, 32'd0, BL[k], k != 0, BD[k]);
    add(1, 0, 1, 2'd2, 32'd2, 4'b0001, 0, 0);
    add(1, 1, 1, 2'd2, 32'd2, 4'b0001, 0, 0);
    add(1, 1, 1, 2'd2, 32'd2, 4'b0001, 0, 0);
    add(1, 1, 1, 2'd2, 32'd2, 4'b0001, 0, 0);
    add(1, 1, 1, 2'd2, 32'd2, 4'b0010, 1, 0);

    foreach (vecs[i]) begin
      if (vecs[i].which) begin
        r4 = vecs[i].rstn; e4 = vecs[i].en; m4 = vecs[i].mode; p4 = vecs[i].period;
      end else begin
        drive3(vecs[i].rstn, vecs[i].en, vecs[i].mode, vecs[i].period);
      end
      edge1();
      chk_out($sformatf("vec%0d", i), vecs[i].which, vecs[i].exp_led,
              vecs[i].exp_tick, vecs[i].exp_dir);
    end

    // Pause for 5 cycles after a step, then switch to ROT_R
    drive3(1'b0, 1'b1, 2'd0, 32'd3);
    edge1(); chk_out("pause rst", 0, 4'b0001, 0, 0);
    r3 = 1'b1;
    for (int k = 1; k <= 3; k++) begin edge1(); chk_out("pause pre", 0, 4'b0001, 0, 0); end
    edge1(); chk_out("pause step1", 0, 4'b0010, 1, 0);
    e3 = 1'b0;
    for (int k = 1; k <= 5; k++) begin edge1(); chk_out("pause hold", 0, 4'b0010, 0, 0); end
    e3 = 1'b1;
    for (int k = 1; k <= 3; k++) begin edge1(); chk_out("pause resume", 0, 4'b0010, 0, 0); end
    edge1(); chk_out("pause step2", 0, 4'b0100, 1, 0);
    m3 = 2'd1;
    edge1(); chk_out("rotr load", 0, 4'b0001, 0, 0);
    for (int k = 1; k <= 3; k++) begin edge1(); chk_out("rotr wait", 0, 4'b0001, 0, 0); end
    edge1(); chk_out("rotr step", 0, 4'b0100, 1, 0);
    e3 = 1'b0; m3 = 2'd3;
    edge1(); chk_out("mode while off", 0, 4'b0000, 0, 0);
    edge1(); chk_out("mode while off hold", 0, 4'b0000, 0, 0);

    // Shrink period from 100 to 10 at cnt=50
    drive3(1'b0, 1'b1, 2'd0, 32'd100);
    edge1(); chk_out("shrink rst", 0, 4'b0001, 0, 0);
    r3 = 1'b1;
    saw_tick = 1'b0;
    for (int k = 1; k <= 50; k++) begin edge1(); saw_tick |= t3; end
    chk("shrink no early tick", 32'(saw_tick), 32'd0);
    chk("shrink led before", 32'(led3), 32'd1);
    p3 = 32'd10;
    edge1(); chk_out("shrink immediate", 0, 4'b0010, 1, 0);
    saw_tick = 1'b0;
    for (int k = 1; k <= 10; k++) begin edge1(); saw_tick |= t3; end
    chk("shrink gap no tick", 32'(saw_tick), 32'd0);
    edge1(); chk_out("shrink step2", 0, 4'b0100, 1, 0);
    for (int k = 1; k <= 10; k++) edge1();
    edge1(); chk_out("shrink step3", 0, 4'b0001, 1, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
